// File: rtl/clkdiv_multi_if.sv
// Configuration port for clkdiv_multi: valid/ready write of a per-channel divider.
// Optional macro CLKDIV_DUTY_EN adds cfg_high, the programmable high time.
interface clkdiv_multi_if #(
    parameter int WIDTH = 32,
    parameter int CH_W  = 2
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [WIDTH-1:0] cfg_div;
`ifdef CLKDIV_DUTY_EN
    logic [WIDTH-1:0] cfg_high;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, output cfg_high, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, input cfg_high, output cfg_ready);
`else
    modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
`endif
endinterface

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH independent runtime-programmable clock dividers off clk_in.
// Each channel has a registered clk_out and a one-cycle tick at every period start.
// New dividers land in a shadow register and only take effect at a period
// boundary (wrap), a restart, or immediately when the channel is stopped.
// Optional macro CLKDIV_DUTY_EN: per-channel programmable high time (cfg_high).
module clkdiv_multi #(
    parameter int               NCH       = 4,
    parameter int               WIDTH     = 32,
    parameter int               CH_W      = 2,
    parameter logic [WIDTH-1:0] RESET_DIV = '0
) (
    input  logic           clk_in,
    input  logic           rst_n,
    clkdiv_multi_if.slave  cfg,
    input  logic [NCH-1:0] restart,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pending
);

    logic cfg_ready_w;

    // Accept a write only when the addressed channel exists and its shadow is free.
    always_comb begin
        cfg_ready_w = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                cfg_ready_w = ~pending[i];
            end
        end
    end

    assign cfg.cfg_ready = cfg_ready_w;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [WIDTH-1:0] count_reg, count_next;
            logic [WIDTH-1:0] div_act_reg, div_act_next;
            logic [WIDTH-1:0] shadow_reg;
            logic [WIDTH-1:0] high_next;
            logic             pending_reg, pending_next;
            logic             clk_out_reg, clk_out_next;
            logic             tick_reg, tick_next;
            logic             cfg_fire, running, wrap, apply;
`ifdef CLKDIV_DUTY_EN
            logic [WIDTH-1:0] high_act_reg;
            logic [WIDTH-1:0] high_shadow_reg;
`endif

            assign cfg_fire = cfg.cfg_valid & cfg_ready_w & (cfg.cfg_ch == CH_W'(gi));
            assign running  = (div_act_reg != '0);
            assign wrap     = running && (count_reg == div_act_reg - WIDTH'(1));

            // Next count/tick, shadow application at boundaries, and registered clk_out level.
            always_comb begin
                apply      = 1'b0;
                count_next = '0;
                tick_next  = 1'b0;
                if (restart[gi] || !running) begin
                    // Restart or stopped: count parks at 0; any pending divider lands now.
                    apply = pending_reg;
                end else if (wrap) begin
                    tick_next = 1'b1;
                    apply     = pending_reg;
                end else begin
                    count_next = count_reg + WIDTH'(1);
                end
                div_act_next = apply ? shadow_reg : div_act_reg;
`ifdef CLKDIV_DUTY_EN
                high_next = apply ? high_shadow_reg : high_act_reg;
`else
                high_next = div_act_next >> 1;
`endif
                // A transfer can only happen while pending is clear, so it never races apply.
                pending_next = cfg_fire ? 1'b1 : (apply ? 1'b0 : pending_reg);
                clk_out_next = !restart[gi] && running && (div_act_next != '0)
                               && (count_next < high_next);
            end

            // Channel state registers; shadow captured on a config transfer.
            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg       <= '0;
                    div_act_reg     <= RESET_DIV;
                    shadow_reg      <= '0;
                    pending_reg     <= 1'b0;
                    clk_out_reg     <= 1'b0;
                    tick_reg        <= 1'b0;
`ifdef CLKDIV_DUTY_EN
                    high_act_reg    <= RESET_DIV >> 1;
                    high_shadow_reg <= '0;
`endif
                end else begin
                    count_reg   <= count_next;
                    div_act_reg <= div_act_next;
                    pending_reg <= pending_next;
                    clk_out_reg <= clk_out_next;
                    tick_reg    <= tick_next;
                    if (cfg_fire) begin
                        shadow_reg <= cfg.cfg_div;
                    end
`ifdef CLKDIV_DUTY_EN
                    high_act_reg <= high_next;
                    if (cfg_fire) begin
                        high_shadow_reg <= cfg.cfg_high;
                    end
`endif
                end
            end

            assign clk_out[gi] = clk_out_reg;
            assign tick[gi]    = tick_reg;
            assign pending[gi] = pending_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clkdiv_multi.sv
// Testbench for clkdiv_multi: per-scenario tasks, expected per-cycle outputs queued
// as stimulus is driven and popped when the DUT has produced the matching edge.
module tb_clkdiv_multi;
    localparam int NCH   = 3;
    localparam int WIDTH = 16;
    localparam int CH_W  = 2;

    logic           clk_in = 1'b0;
    logic           rst_n  = 1'b0;
    logic [NCH-1:0] restart = '0;
    logic [NCH-1:0] clk_out, tick, pending;

    clkdiv_multi_if #(.WIDTH(WIDTH), .CH_W(CH_W)) cfg_bus ();

    clkdiv_multi #(
        .NCH(NCH), .WIDTH(WIDTH), .CH_W(CH_W), .RESET_DIV(16'd0)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .cfg     (cfg_bus),
        .restart (restart),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [NCH-1:0] care;
        logic [NCH-1:0] clk;
        logic [NCH-1:0] tck;
        logic [NCH-1:0] pnd;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cfg_drive(input logic v, input int ch, input int div);
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_ch    = CH_W'(ch);
        cfg_bus.cfg_div   = WIDTH'(div);
`ifdef CLKDIV_DUTY_EN
        cfg_bus.cfg_high  = WIDTH'(div) >> 1;
`endif
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        restart = '0;
        cfg_drive(1'b0, 0, 0);
        sb.delete();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        restart = '0;
        cfg_drive(1'b0, 0, 0);
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (clk_out !== 3'b000) begin n_bad++; $display("FAIL reset_clk_out got=%b exp=000", clk_out); end
        n_cmp++; if (tick !== 3'b000) begin n_bad++; $display("FAIL reset_tick got=%b exp=000", tick); end
        n_cmp++; if (pending !== 3'b000) begin n_bad++; $display("FAIL reset_pending got=%b exp=000", pending); end
        cfg_drive(1'b1, 3, 7);
        #1;
        n_cmp++; if (cfg_bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL ready_bad_ch got=%b exp=0", cfg_bus.cfg_ready); end
        cfg_drive(1'b1, 0, 7);
        #1;
        n_cmp++; if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL ready_ch0 got=%b exp=1", cfg_bus.cfg_ready); end
        cfg_drive(1'b1, 3, 7);
        rst_n = 1'b1;
        step();
        step();
        cfg_drive(1'b0, 0, 0);
        n_cmp++; if (pending !== 3'b000) begin n_bad++; $display("FAIL bad_ch_no_xfer got=%b exp=000", pending); end
        n_cmp++; if (clk_out !== 3'b000 || tick !== 3'b000) begin n_bad++; $display("FAIL stopped_idle clk=%b tick=%b exp=000/000", clk_out, tick); end
        $display("test_reset done");
    endtask

    task automatic test_div4();
        exp_t e;
        do_reset();
        cfg_drive(1'b1, 0, 4);
        #1;
        n_cmp++; if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL div4_ready got=%b exp=1", cfg_bus.cfg_ready); end
        step();
        cfg_drive(1'b0, 0, 4);
        n_cmp++; if (pending !== 3'b001) begin n_bad++; $display("FAIL div4_pend_set got=%b exp=001", pending); end
        step();
        n_cmp++; if (pending !== 3'b000 || clk_out !== 3'b000 || tick !== 3'b000) begin
            n_bad++; $display("FAIL div4_apply pend=%b clk=%b tick=%b exp=000/000/000", pending, clk_out, tick);
        end
        for (int j = 1; j <= 12; j++) begin
            int c;
            c = j % 4;
            e.care = 3'b001; e.clk = '0; e.tck = '0; e.pnd = '0;
            e.clk[0] = (c < 2);
            e.tck[0] = (c == 0);
            sb.push_back(e);
            step();
            e = sb.pop_front();
            n_cmp++; if ((clk_out & e.care) !== (e.clk & e.care)) begin n_bad++; $display("FAIL div4_clk cyc=%0d got=%b exp=%b", j, clk_out & e.care, e.clk); end
            n_cmp++; if ((tick & e.care) !== (e.tck & e.care)) begin n_bad++; $display("FAIL div4_tick cyc=%0d got=%b exp=%b", j, tick & e.care, e.tck); end
            $display("div4 cyc=%0d clk_out=%b tick=%b", j, clk_out[0], tick[0]);
        end
    endtask

    task automatic test_change_div();
        exp_t e;
        do_reset();
        cfg_drive(1'b1, 1, 6);
        step();
        cfg_drive(1'b0, 1, 6);
        step();
        for (int j = 1; j <= 15; j++) begin
            int c;
            logic p;
            if (j == 3) begin
                cfg_drive(1'b1, 1, 3);
                #1;
                n_cmp++; if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL chg_ready_pre got=%b exp=1", cfg_bus.cfg_ready); end
            end
            c = (j <= 5) ? j : (j - 6) % 3;
            p = (j >= 3 && j <= 5);
            e.care = 3'b010; e.clk = '0; e.tck = '0; e.pnd = '0;
            e.clk[1] = (j <= 5) ? (c < 3) : (c < 1);
            e.tck[1] = (j >= 6) && (c == 0);
            e.pnd[1] = p;
            sb.push_back(e);
            step();
            if (j == 3) cfg_drive(1'b0, 1, 3);
            e = sb.pop_front();
            n_cmp++; if ((clk_out & e.care) !== (e.clk & e.care)) begin n_bad++; $display("FAIL chg_clk cyc=%0d got=%b exp=%b", j, clk_out & e.care, e.clk); end
            n_cmp++; if ((tick & e.care) !== (e.tck & e.care)) begin n_bad++; $display("FAIL chg_tick cyc=%0d got=%b exp=%b", j, tick & e.care, e.tck); end
            n_cmp++; if ((pending & e.care) !== (e.pnd & e.care)) begin n_bad++; $display("FAIL chg_pend cyc=%0d got=%b exp=%b", j, pending & e.care, e.pnd); end
            n_cmp++; if (cfg_bus.cfg_ready !== !p) begin n_bad++; $display("FAIL chg_ready cyc=%0d got=%b exp=%b", j, cfg_bus.cfg_ready, !p); end
            $display("chg cyc=%0d clk_out=%b tick=%b pending=%b", j, clk_out[1], tick[1], pending[1]);
        end
    endtask

    task automatic test_pending_block();
        exp_t e;
        do_reset();
        cfg_drive(1'b1, 1, 8);
        step();
        cfg_drive(1'b0, 1, 8);
        step();
        cfg_drive(1'b1, 1, 5);
        step();
        cfg_drive(1'b1, 1, 2);
        #1;
        n_cmp++; if (cfg_bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL blk_ready_ch1 got=%b exp=0", cfg_bus.cfg_ready); end
        step();
        n_cmp++; if (pending !== 3'b010) begin n_bad++; $display("FAIL blk_pend_a got=%b exp=010", pending); end
        cfg_drive(1'b1, 2, 3);
        #1;
        n_cmp++; if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL blk_ready_ch2 got=%b exp=1", cfg_bus.cfg_ready); end
        step();
        cfg_drive(1'b0, 2, 3);
        n_cmp++; if (pending !== 3'b110) begin n_bad++; $display("FAIL blk_pend_b got=%b exp=110", pending); end
        for (int ed = 5; ed <= 19; ed++) begin
            int c1, c2;
            c1 = (ed <= 8) ? ed - 1 : (ed - 9) % 5;
            c2 = (ed - 5) % 3;
            e.care = 3'b110; e.clk = '0; e.tck = '0; e.pnd = '0;
            e.clk[1] = (ed <= 8) ? (c1 < 4) : (c1 < 2);
            e.tck[1] = (ed >= 9) && (c1 == 0);
            e.pnd[1] = (ed <= 8);
            e.clk[2] = (ed > 5) && (c2 == 0);
            e.tck[2] = (ed > 5) && (c2 == 0);
            sb.push_back(e);
            step();
            e = sb.pop_front();
            n_cmp++; if ((clk_out & e.care) !== (e.clk & e.care)) begin n_bad++; $display("FAIL blk_clk edge=%0d got=%b exp=%b", ed, clk_out & e.care, e.clk); end
            n_cmp++; if ((tick & e.care) !== (e.tck & e.care)) begin n_bad++; $display("FAIL blk_tick edge=%0d got=%b exp=%b", ed, tick & e.care, e.tck); end
            n_cmp++; if ((pending & e.care) !== (e.pnd & e.care)) begin n_bad++; $display("FAIL blk_pend edge=%0d got=%b exp=%b", ed, pending & e.care, e.pnd); end
            $display("blk edge=%0d clk_out=%b tick=%b pending=%b", ed, clk_out, tick, pending);
        end
    endtask

    task automatic test_restart();
        exp_t e;
        int both, first;
        both  = 0;
        first = 0;
        do_reset();
        cfg_drive(1'b1, 0, 5);
        step();
        cfg_drive(1'b1, 1, 7);
        step();
        cfg_drive(1'b0, 1, 7);
        step();
        step();
        n_cmp++; if (clk_out[1] !== 1'b1) begin n_bad++; $display("FAIL rst_pre_clk1 got=%b exp=1", clk_out[1]); end
        restart = 3'b011;
        step();
        restart = 3'b000;
        n_cmp++; if (clk_out[1:0] !== 2'b00 || tick[1:0] !== 2'b00) begin
            n_bad++; $display("FAIL restart_zero clk=%b tick=%b exp=00/00", clk_out[1:0], tick[1:0]);
        end
        for (int k = 1; k <= 72; k++) begin
            int c0, c1;
            c0 = k % 5;
            c1 = k % 7;
            e.care = 3'b011; e.clk = '0; e.tck = '0; e.pnd = '0;
            e.clk[0] = (c0 < 2);
            e.clk[1] = (c1 < 3);
            e.tck[0] = (c0 == 0);
            e.tck[1] = (c1 == 0);
            sb.push_back(e);
            step();
            e = sb.pop_front();
            n_cmp++; if ((clk_out & e.care) !== (e.clk & e.care)) begin n_bad++; $display("FAIL rst_clk k=%0d got=%b exp=%b", k, clk_out & e.care, e.clk); end
            n_cmp++; if ((tick & e.care) !== (e.tck & e.care)) begin n_bad++; $display("FAIL rst_tick k=%0d got=%b exp=%b", k, tick & e.care, e.tck); end
            if (tick[0] && tick[1]) begin
                both++;
                if (first == 0) first = k;
            end
            $display("restart k=%0d clk_out=%b tick=%b", k, clk_out[1:0], tick[1:0]);
        end
        n_cmp++; if (first !== 35) begin n_bad++; $display("FAIL rst_first_coincide got=%0d exp=35", first); end
        n_cmp++; if (both !== 2) begin n_bad++; $display("FAIL rst_coincide_count got=%0d exp=2", both); end
    endtask

    task automatic test_div1_stop();
        exp_t e;
        do_reset();
        cfg_drive(1'b1, 2, 1);
        step();
        cfg_drive(1'b1, 0, 4);
        step();
        cfg_drive(1'b0, 0, 4);
        step();
        for (int ed = 3; ed <= 12; ed++) begin
            int c;
            if (ed == 4) cfg_drive(1'b1, 0, 0);
            c = ed - 2;
            e.care = 3'b101; e.clk = '0; e.tck = '0; e.pnd = '0;
            e.clk[0] = (ed <= 5) && (c < 2);
            e.tck[0] = (ed == 6);
            e.pnd[0] = (ed == 4 || ed == 5);
            e.tck[2] = 1'b1;
            sb.push_back(e);
            step();
            if (ed == 4) cfg_drive(1'b0, 0, 0);
            e = sb.pop_front();
            n_cmp++; if ((clk_out & e.care) !== (e.clk & e.care)) begin n_bad++; $display("FAIL stop_clk edge=%0d got=%b exp=%b", ed, clk_out & e.care, e.clk); end
            n_cmp++; if ((tick & e.care) !== (e.tck & e.care)) begin n_bad++; $display("FAIL stop_tick edge=%0d got=%b exp=%b", ed, tick & e.care, e.tck); end
            n_cmp++; if ((pending & e.care) !== (e.pnd & e.care)) begin n_bad++; $display("FAIL stop_pend edge=%0d got=%b exp=%b", ed, pending & e.care, e.pnd); end
            $display("stop edge=%0d clk_out=%b tick=%b pending=%b", ed, clk_out, tick, pending);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg_drive(1'b1, 2, 1);
        step();
        cfg_drive(1'b1, 1, 4);
        step();
        cfg_drive(1'b0, 1, 4);
        step();
        cfg_drive(1'b1, 0, 9);
        step();
        cfg_drive(1'b0, 0, 9);
        n_cmp++; if (clk_out[1] !== 1'b1 || tick[2] !== 1'b1 || pending[0] !== 1'b1) begin
            n_bad++; $display("FAIL arst_pre clk1=%b tick2=%b pend0=%b exp=1/1/1", clk_out[1], tick[2], pending[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (clk_out !== 3'b000 || tick !== 3'b000 || pending !== 3'b000) begin
            n_bad++; $display("FAIL arst_immediate clk=%b tick=%b pend=%b exp=000/000/000", clk_out, tick, pending);
        end
        $display("async_reset clk_out=%b tick=%b pending=%b", clk_out, tick, pending);
        step();
        rst_n = 1'b1;
    endtask

`ifdef CLKDIV_DUTY_EN
    task automatic test_duty();
        exp_t e;
        do_reset();
        cfg_drive(1'b1, 0, 10);
        cfg_bus.cfg_high = 16'd3;
        step();
        cfg_drive(1'b0, 0, 10);
        step();
        for (int ed = 2; ed <= 45; ed++) begin
            int c;
            if (ed == 24) begin
                cfg_drive(1'b1, 0, 10);
                cfg_bus.cfg_high = 16'd10;
            end
            c = (ed - 1) % 10;
            e.care = 3'b001; e.clk = '0; e.tck = '0; e.pnd = '0;
            e.clk[0] = (ed >= 31) ? 1'b1 : (c < 3);
            e.tck[0] = (c == 0);
            e.pnd[0] = (ed >= 24 && ed <= 30);
            sb.push_back(e);
            step();
            if (ed == 24) cfg_drive(1'b0, 0, 10);
            e = sb.pop_front();
            n_cmp++; if ((clk_out & e.care) !== (e.clk & e.care)) begin n_bad++; $display("FAIL duty_clk edge=%0d got=%b exp=%b", ed, clk_out & e.care, e.clk); end
            n_cmp++; if ((tick & e.care) !== (e.tck & e.care)) begin n_bad++; $display("FAIL duty_tick edge=%0d got=%b exp=%b", ed, tick & e.care, e.tck); end
            n_cmp++; if ((pending & e.care) !== (e.pnd & e.care)) begin n_bad++; $display("FAIL duty_pend edge=%0d got=%b exp=%b", ed, pending & e.care, e.pnd); end
            $display("duty edge=%0d clk_out=%b tick=%b", ed, clk_out[0], tick[0]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_div4();
        test_change_div();
        test_pending_block();
        test_restart();
        test_div1_stop();
        test_async_reset();
`ifdef CLKDIV_DUTY_EN
        test_duty();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
